// File: rtl/add_pipe.sv
// Pipelined adder/subtractor whose carry chain is split into STAGES segments, with operand skew and result de-skew.
// Optional saturation of Q on signed overflow when ADD_PIPE_SAT_EN is defined; default build wraps.
module add_pipe #(
  parameter int WIDTH  = 24,
  parameter int STAGES = 3
) (
  input  logic             CLK,
  input  logic             SCLR,
  input  logic             CE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  input  logic             VI,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             OV,
  output logic             VO
);

  localparam int SEG = WIDTH / STAGES;

  logic [WIDTH-1:0]  b_eff;
  logic [STAGES-1:0] cy;
  logic [WIDTH-1:0]  q_pre;
  logic [WIDTH-1:0]  q_nxt;
  logic              a_msb;
  logic              b_msb;
  logic              ov_nxt;
  logic [WIDTH-1:0]  q_p;
  logic              ov_p;
  logic [STAGES-1:0] vld_p;

  assign b_eff = SUB ? ~B : B;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_seg
      logic [SEG-1:0] a_in;
      logic [SEG-1:0] b_in;
      logic           cin;
      logic [SEG:0]   sum_c;
      logic           cy_p;

      // Input skew: segment k sees its operands k registers late, aligned with the incoming carry.
      if (k == 0) begin : g_head
        assign a_in = A[SEG-1:0];
        assign b_in = b_eff[SEG-1:0];
        assign cin  = CI;
      end else begin : g_skew
        logic [SEG-1:0] a_sk_p [k];
        logic [SEG-1:0] b_sk_p [k];

        always_ff @(posedge CLK) begin
          if (SCLR) begin
            for (int j = 0; j < k; j++) begin
              a_sk_p[j] <= '0;
              b_sk_p[j] <= '0;
            end
          end else if (CE) begin
            a_sk_p[0] <= A[k*SEG +: SEG];
            b_sk_p[0] <= b_eff[k*SEG +: SEG];
            for (int j = 1; j < k; j++) begin
              a_sk_p[j] <= a_sk_p[j-1];
              b_sk_p[j] <= b_sk_p[j-1];
            end
          end
        end

        assign a_in = a_sk_p[k-1];
        assign b_in = b_sk_p[k-1];
        assign cin  = cy[k-1];
      end

      assign sum_c = {1'b0, a_in} + {1'b0, b_in} + {{SEG{1'b0}}, cin};

      // Stage k boundary: carry out of this segment
      always_ff @(posedge CLK) begin
        if (SCLR)
          cy_p <= 1'b0;
        else if (CE)
          cy_p <= sum_c[SEG];
      end
      assign cy[k] = cy_p;

      // Output de-skew: finished low segments wait for the top segment.
      if (k == STAGES - 1) begin : g_top
        assign q_pre[k*SEG +: SEG] = sum_c[SEG-1:0];
        assign a_msb = a_in[SEG-1];
        assign b_msb = b_in[SEG-1];
      end else begin : g_dsk
        logic [SEG-1:0] s_dsk_p [STAGES-1-k];

        always_ff @(posedge CLK) begin
          if (SCLR) begin
            for (int j = 0; j < STAGES - 1 - k; j++)
              s_dsk_p[j] <= '0;
          end else if (CE) begin
            s_dsk_p[0] <= sum_c[SEG-1:0];
            for (int j = 1; j < STAGES - 1 - k; j++)
              s_dsk_p[j] <= s_dsk_p[j-1];
          end
        end

        assign q_pre[k*SEG +: SEG] = s_dsk_p[STAGES-2-k];
      end
    end
  endgenerate

  assign ov_nxt = (a_msb == b_msb) && (q_pre[WIDTH-1] != a_msb);

`ifdef ADD_PIPE_SAT_EN
  function automatic logic signed [WIDTH-1:0] sat_q(input logic signed [WIDTH-1:0] sum,
                                                    input logic neg, input logic ovf);
    if (!ovf)
      return sum;
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign q_nxt = sat_q(q_pre, a_msb, ov_nxt);
`else
  assign q_nxt = q_pre;
`endif

  // Final stage boundary: result, overflow and valid line
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      q_p   <= '0;
      ov_p  <= 1'b0;
      vld_p <= '0;
    end else if (CE) begin
      q_p      <= q_nxt;
      ov_p     <= ov_nxt;
      vld_p[0] <= VI;
      for (int j = 1; j < STAGES; j++)
        vld_p[j] <= vld_p[j-1];
    end
  end

  assign Q  = q_p;
  assign CO = cy[STAGES-1];
  assign OV = ov_p;
  assign VO = vld_p[STAGES-1];

endmodule

// File: tb/tb_add_pipe.sv
// Directed bench for add_pipe at WIDTH=24, STAGES=3: streaming vector table, stall table, reset sequences.
module tb_add_pipe;

  localparam int W = 24;

  logic         CLK = 1'b0;
  logic         SCLR, CE, CI, SUB, VI;
  logic [W-1:0] A, B, Q;
  logic         CO, OV, VO;

  int errors = 0;
  int checks = 0;

  add_pipe #(.WIDTH(W), .STAGES(3)) dut (
    .CLK(CLK), .SCLR(SCLR), .CE(CE), .A(A), .B(B), .CI(CI), .SUB(SUB), .VI(VI),
    .Q(Q), .CO(CO), .OV(OV), .VO(VO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub;
    logic [W-1:0] q;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic         ce;
    logic         vi;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         vo;
    logic [W-1:0] q;
  } stall_t;

  localparam int NV = 12;
  localparam int NS = 8;
  vec_t   vt [NV];
  stall_t st [NS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ce, input logic vi, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ci, input logic sub);
    CE = ce; VI = vi; A = a; B = b; CI = ci; SUB = sub;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    vt[0]  = '{24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0};
    vt[1]  = '{24'h000001, 24'h000002, 1'b0, 1'b0, 24'h000003, 1'b0, 1'b0};
    vt[2]  = '{24'h000010, 24'h000020, 1'b0, 1'b0, 24'h000030, 1'b0, 1'b0};
    vt[3]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 24'hFFFFFE, 1'b1, 1'b0};
    vt[4]  = '{24'h000005, 24'h000007, 1'b1, 1'b1, 24'hFFFFFE, 1'b0, 1'b0};
`ifdef ADD_PIPE_SAT_EN
    vt[5]  = '{24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 24'h7FFFFF, 1'b0, 1'b1};
    vt[6]  = '{24'h800000, 24'h800000, 1'b0, 1'b0, 24'h800000, 1'b1, 1'b1};
    vt[7]  = '{24'h800000, 24'h000001, 1'b1, 1'b1, 24'h800000, 1'b1, 1'b1};
    vt[11] = '{24'h400000, 24'h400000, 1'b0, 1'b0, 24'h7FFFFF, 1'b0, 1'b1};
`else
    vt[5]  = '{24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b1};
    vt[6]  = '{24'h800000, 24'h800000, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1};
    vt[7]  = '{24'h800000, 24'h000001, 1'b1, 1'b1, 24'h7FFFFF, 1'b1, 1'b1};
    vt[11] = '{24'h400000, 24'h400000, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b1};
`endif
    vt[8]  = '{24'h00FFFF, 24'h000001, 1'b0, 1'b0, 24'h010000, 1'b0, 1'b0};
    vt[9]  = '{24'h0000FF, 24'h000000, 1'b1, 1'b0, 24'h000100, 1'b0, 1'b0};
    vt[10] = '{24'h123456, 24'h123456, 1'b1, 1'b1, 24'h000000, 1'b1, 1'b0};

    // s0 = 5+5 and s1 = 1+2 enter back to back, then the pipe stalls twice, runs, stalls once with s0 at the output.
    st[0] = '{1'b1, 1'b1, 24'h000005, 24'h000005, 1'b0, 24'h000000};
    st[1] = '{1'b1, 1'b1, 24'h000001, 24'h000002, 1'b0, 24'h000000};
    st[2] = '{1'b0, 1'b0, 24'h000000, 24'h000000, 1'b0, 24'h000000};
    st[3] = '{1'b0, 1'b0, 24'h000000, 24'h000000, 1'b0, 24'h000000};
    st[4] = '{1'b1, 1'b0, 24'h000000, 24'h000000, 1'b1, 24'h00000A};
    st[5] = '{1'b0, 1'b0, 24'h000000, 24'h000000, 1'b1, 24'h00000A};
    st[6] = '{1'b1, 1'b0, 24'h000000, 24'h000000, 1'b1, 24'h000003};
    st[7] = '{1'b1, 1'b0, 24'h000000, 24'h000000, 1'b0, 24'h000000};

    SCLR = 1'b1;
    idle();
    step();
    step();
    chk("rst_q",  64'(Q),  64'h0);
    chk("rst_co", 64'(CO), 64'h0);
    chk("rst_ov", 64'(OV), 64'h0);
    chk("rst_vo", 64'(VO), 64'h0);
    SCLR = 1'b0;

    // Streaming: one vector per cycle, each result 3 cycles after entry
    for (int c = 0; c < NV + 3; c++) begin
      if (c < NV)
        drive(1'b1, 1'b1, vt[c].a, vt[c].b, vt[c].ci, vt[c].sub);
      else
        idle();
      step();
      if (c >= 2 && c - 2 < NV) begin
        chk($sformatf("vec%0d_vo", c - 2), 64'(VO), 64'h1);
        chk($sformatf("vec%0d_q",  c - 2), 64'(Q),  64'(vt[c-2].q));
        chk($sformatf("vec%0d_co", c - 2), 64'(CO), 64'(vt[c-2].co));
        chk($sformatf("vec%0d_ov", c - 2), 64'(OV), 64'(vt[c-2].ov));
      end else if (c - 2 == NV) begin
        chk("stream_tail_vo", 64'(VO), 64'h0);
      end
    end
    idle();
    step();
    step();
    step();

    for (int s = 0; s < NS; s++) begin
      drive(st[s].ce, st[s].vi, st[s].a, st[s].b, 1'b0, 1'b0);
      step();
      chk($sformatf("stall%0d_vo", s), 64'(VO), 64'(st[s].vo));
      if (st[s].vo)
        chk($sformatf("stall%0d_q", s), 64'(Q), 64'(st[s].q));
    end
    idle();
    step();
    step();
    step();

    // Two valid samples in flight, then a one-cycle SCLR: both must vanish
    drive(1'b1, 1'b1, 24'hFFFFFF, 24'h000001, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 24'h7FFFFF, 24'h000001, 1'b0, 1'b0);
    step();
    idle();
    SCLR = 1'b1;
    step();
    SCLR = 1'b0;
    chk("sclr_q",  64'(Q),  64'h0);
    chk("sclr_vo", 64'(VO), 64'h0);
    chk("sclr_co", 64'(CO), 64'h0);
    chk("sclr_ov", 64'(OV), 64'h0);
    for (int s = 0; s < 4; s++) begin
      step();
      chk($sformatf("sclr_after%0d_vo", s), 64'(VO), 64'h0);
    end

    // SCLR with CE low still clears a sample parked in the pipe
    drive(1'b1, 1'b1, 24'h000011, 24'h000022, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    SCLR = 1'b1;
    step();
    SCLR = 1'b0;
    chk("sclr_ce0_vo", 64'(VO), 64'h0);
    idle();
    for (int s = 0; s < 3; s++) begin
      step();
      chk($sformatf("sclr_ce0_after%0d_vo", s), 64'(VO), 64'h0);
    end
    chk("sclr_ce0_q", 64'(Q), 64'h0);

    // First valid sample after reset arrives exactly 3 cycles later
    drive(1'b1, 1'b1, 24'h000100, 24'h000200, 1'b0, 1'b0);
    step();
    idle();
    step();
    chk("post_rst_early_vo", 64'(VO), 64'h0);
    step();
    chk("post_rst_vo", 64'(VO), 64'h1);
    chk("post_rst_q",  64'(Q),  64'h000300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
